// File: rtl/upsp_frame_sequencer.sv
// Frame-batch sequencer: per frame it sets UPSTART over AXI4-Lite, waits for the update-done
// interrupt, confirms UPEND bit 0 by readback, then clears UPEND before the next frame.
module upsp_frame_sequencer #(
   parameter int                        AXI_ADDR_WIDTH = 32,
   parameter int                        AXI_DATA_WIDTH = 32,
   parameter logic [AXI_ADDR_WIDTH-1:0] UPSTR_ADDR     = 'h0,
   parameter logic [AXI_ADDR_WIDTH-1:0] UPENDR_ADDR    = 'h4,
   parameter int                        TIMEOUT_CYCLES = 2**20
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          start,
   input  logic [15:0]                   frame_num,
   output logic                          busy,
   output logic                          done,
   output logic                          err,
   output logic [1:0]                    err_code,
   output logic [15:0]                   frames_done,
   input  logic                          interrupt_updone,
   output logic                          m_axi_awvalid,
   input  logic                          m_axi_awready,
   output logic [AXI_ADDR_WIDTH-1:0]     m_axi_awaddr,
   output logic [2:0]                    m_axi_awprot,
   output logic                          m_axi_wvalid,
   input  logic                          m_axi_wready,
   output logic [AXI_DATA_WIDTH-1:0]     m_axi_wdata,
   output logic [AXI_DATA_WIDTH/8-1:0]   m_axi_wstrb,
   input  logic                          m_axi_bvalid,
   output logic                          m_axi_bready,
   input  logic [1:0]                    m_axi_bresp,
   output logic                          m_axi_arvalid,
   input  logic                          m_axi_arready,
   output logic [AXI_ADDR_WIDTH-1:0]     m_axi_araddr,
   output logic [2:0]                    m_axi_arprot,
   input  logic                          m_axi_rvalid,
   output logic                          m_axi_rready,
   input  logic [AXI_DATA_WIDTH-1:0]     m_axi_rdata,
   input  logic [1:0]                    m_axi_rresp
);
   localparam int STRB_W = AXI_DATA_WIDTH / 8;
   localparam logic [AXI_DATA_WIDTH-1:0] WDATA_SET = {{(AXI_DATA_WIDTH-1){1'b0}}, 1'b1};

   localparam logic [3:0] S_IDLE       = 4'd0;
   localparam logic [3:0] S_WR_START   = 4'd1;
   localparam logic [3:0] S_WR_START_B = 4'd2;
   localparam logic [3:0] S_WAIT_DONE  = 4'd3;
   localparam logic [3:0] S_RD_END     = 4'd4;
   localparam logic [3:0] S_RD_END_R   = 4'd5;
   localparam logic [3:0] S_WR_CLR     = 4'd6;
   localparam logic [3:0] S_WR_CLR_B   = 4'd7;
   localparam logic [3:0] S_NEXT       = 4'd8;
   localparam logic [3:0] S_FAIL       = 4'd9;

   logic [3:0]                state_q, state_d;
   logic [15:0]               count_q, count_d;
   logic [15:0]               frames_done_q, frames_done_d;
   logic                      err_q, err_d;
   logic [1:0]                err_code_q, err_code_d;
   logic                      done_q, done_d;
   logic                      awvalid_q, awvalid_d;
   logic                      wvalid_q, wvalid_d;
   logic                      arvalid_q, arvalid_d;
   logic [AXI_ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
   logic [AXI_DATA_WIDTH-1:0] wdata_q, wdata_d;
   logic [AXI_ADDR_WIDTH-1:0] araddr_q, araddr_d;
   logic [31:0]               cnt_q, cnt_d;

   logic        aw_hs, w_hs;
   logic [15:0] frames_inc;
   logic        unused_rdata;

   assign aw_hs        = awvalid_q & m_axi_awready;
   assign w_hs         = wvalid_q & m_axi_wready;
   assign frames_inc   = (frames_done_q == 16'hFFFF) ? 16'hFFFF : frames_done_q + 16'd1;
   // Only bit 0 of the UPEND readback carries meaning.
   assign unused_rdata = ^m_axi_rdata[AXI_DATA_WIDTH-1:1];

   always_comb begin
      state_d       = state_q;
      count_d       = count_q;
      frames_done_d = frames_done_q;
      err_d         = err_q;
      err_code_d    = err_code_q;
      done_d        = 1'b0;
      awvalid_d     = awvalid_q;
      wvalid_d      = wvalid_q;
      arvalid_d     = arvalid_q;
      awaddr_d      = awaddr_q;
      wdata_d       = wdata_q;
      araddr_d      = araddr_q;
      cnt_d         = cnt_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               if (frame_num != 16'd0) begin
                  count_d       = frame_num;
                  frames_done_d = '0;
                  err_d         = 1'b0;
                  err_code_d    = 2'd0;
                  state_d       = S_WR_START;
                  awvalid_d     = 1'b1;
                  wvalid_d      = 1'b1;
                  awaddr_d      = UPSTR_ADDR;
                  wdata_d       = WDATA_SET;
               end else begin
                  done_d = 1'b1;
               end
            end
         end
         S_WR_START, S_WR_CLR: begin
            if (aw_hs) awvalid_d = 1'b0;
            if (w_hs)  wvalid_d  = 1'b0;
            if ((!awvalid_q || aw_hs) && (!wvalid_q || w_hs))
               state_d = (state_q == S_WR_START) ? S_WR_START_B : S_WR_CLR_B;
         end
         S_WR_START_B, S_WR_CLR_B: begin
            if (m_axi_bvalid) begin
               if (m_axi_bresp != 2'b00) begin
                  state_d    = S_FAIL;
                  err_d      = 1'b1;
                  err_code_d = 2'd1;
               end else if (state_q == S_WR_START_B) begin
                  state_d = S_WAIT_DONE;
                  cnt_d   = '0;
               end else begin
                  state_d = S_NEXT;
               end
            end
         end
         S_WAIT_DONE: begin
            // The interrupt takes priority over a coincident timeout.
            if (interrupt_updone) begin
               state_d   = S_RD_END;
               arvalid_d = 1'b1;
               araddr_d  = UPENDR_ADDR;
            end else if (cnt_q == 32'(TIMEOUT_CYCLES - 1)) begin
               state_d    = S_FAIL;
               err_d      = 1'b1;
               err_code_d = 2'd3;
            end else begin
               cnt_d = cnt_q + 32'd1;
            end
         end
         S_RD_END: begin
            if (arvalid_q && m_axi_arready) begin
               arvalid_d = 1'b0;
               state_d   = S_RD_END_R;
            end
         end
         S_RD_END_R: begin
            if (m_axi_rvalid) begin
               if ((m_axi_rresp != 2'b00) || !m_axi_rdata[0]) begin
                  state_d    = S_FAIL;
                  err_d      = 1'b1;
                  err_code_d = 2'd2;
               end else begin
                  state_d   = S_WR_CLR;
                  awvalid_d = 1'b1;
                  wvalid_d  = 1'b1;
                  awaddr_d  = UPENDR_ADDR;
                  wdata_d   = '0;
               end
            end
         end
         S_NEXT: begin
            frames_done_d = frames_inc;
            if (frames_inc == count_q) begin
               state_d = S_IDLE;
               done_d  = 1'b1;
            end else begin
               state_d   = S_WR_START;
               awvalid_d = 1'b1;
               wvalid_d  = 1'b1;
               awaddr_d  = UPSTR_ADDR;
               wdata_d   = WDATA_SET;
            end
         end
         S_FAIL: begin
            state_d = S_IDLE;
            done_d  = 1'b1;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= S_IDLE;
         count_q       <= '0;
         frames_done_q <= '0;
         err_q         <= 1'b0;
         err_code_q    <= 2'd0;
         done_q        <= 1'b0;
         awvalid_q     <= 1'b0;
         wvalid_q      <= 1'b0;
         arvalid_q     <= 1'b0;
         awaddr_q      <= '0;
         wdata_q       <= '0;
         araddr_q      <= '0;
         cnt_q         <= '0;
      end else begin
         state_q       <= state_d;
         count_q       <= count_d;
         frames_done_q <= frames_done_d;
         err_q         <= err_d;
         err_code_q    <= err_code_d;
         done_q        <= done_d;
         awvalid_q     <= awvalid_d;
         wvalid_q      <= wvalid_d;
         arvalid_q     <= arvalid_d;
         awaddr_q      <= awaddr_d;
         wdata_q       <= wdata_d;
         araddr_q      <= araddr_d;
         cnt_q         <= cnt_d;
      end
   end

   assign busy          = (state_q != S_IDLE);
   assign done          = done_q;
   assign err           = err_q;
   assign err_code      = err_code_q;
   assign frames_done   = frames_done_q;
   assign m_axi_awvalid = awvalid_q;
   assign m_axi_awaddr  = awaddr_q;
   assign m_axi_awprot  = 3'b000;
   assign m_axi_wvalid  = wvalid_q;
   assign m_axi_wdata   = wdata_q;
   assign m_axi_wstrb   = {STRB_W{1'b1}};
   assign m_axi_bready  = (state_q == S_WR_START_B) || (state_q == S_WR_CLR_B);
   assign m_axi_arvalid = arvalid_q;
   assign m_axi_araddr  = araddr_q;
   assign m_axi_arprot  = 3'b000;
   assign m_axi_rready  = (state_q == S_RD_END_R);
endmodule

// File: tb/tb_upsp_frame_sequencer.sv
// Bench for upsp_frame_sequencer: AXI4-Lite slave model with a write scoreboard, plus
// scenario tasks for normal batches, handshake timing, error paths and reset.
module tb_upsp_frame_sequencer;
   localparam logic [31:0] UPSTR  = 32'h0;
   localparam logic [31:0] UPENDR = 32'h4;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
   } wr_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [15:0] frame_num = '0;
   logic        busy, done, err;
   logic [1:0]  err_code;
   logic [15:0] frames_done;
   logic        interrupt_updone = 1'b0;
   logic        m_axi_awvalid, m_axi_awready = 1'b0;
   logic [31:0] m_axi_awaddr;
   logic [2:0]  m_axi_awprot;
   logic        m_axi_wvalid, m_axi_wready = 1'b0;
   logic [31:0] m_axi_wdata;
   logic [3:0]  m_axi_wstrb;
   logic        m_axi_bvalid = 1'b0, m_axi_bready;
   logic [1:0]  m_axi_bresp = 2'b00;
   logic        m_axi_arvalid, m_axi_arready = 1'b0;
   logic [31:0] m_axi_araddr;
   logic [2:0]  m_axi_arprot;
   logic        m_axi_rvalid = 1'b0, m_axi_rready;
   logic [31:0] m_axi_rdata = '0;
   logic [1:0]  m_axi_rresp = 2'b00;

   upsp_frame_sequencer #(.TIMEOUT_CYCLES(16)) dut (
      .clk(clk), .rst(rst), .start(start), .frame_num(frame_num),
      .busy(busy), .done(done), .err(err), .err_code(err_code), .frames_done(frames_done),
      .interrupt_updone(interrupt_updone),
      .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
      .m_axi_awaddr(m_axi_awaddr), .m_axi_awprot(m_axi_awprot),
      .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
      .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
      .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready), .m_axi_bresp(m_axi_bresp),
      .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
      .m_axi_araddr(m_axi_araddr), .m_axi_arprot(m_axi_arprot),
      .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
      .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp)
   );

   always #5 clk = ~clk;

   int  n_cmp = 0;
   int  n_fail = 0;
   wr_t exp_q[$];

   // Slave-model configuration set by the scenario tasks
   int          aw_delay = 0;
   int          w_delay = 0;
   int          irq_delay = 10;
   logic [31:0] rd_value = 32'h1;
   bit          bresp_err_next = 1'b0;

   // Slave-model state and observations
   int          ncyc = 0;
   bit          hs_aw, hs_w, hs_b, hs_ar, hs_r;
   bit          got_aw, got_w, irq_armed, err_prev, wait_entered;
   int          irq_cnt = 0;
   int          aw_run = 0, w_run = 0, aw_len_first = -1, w_len_first = -1, aw_unstable = 0;
   logic [31:0] aw_addr_hold, cap_addr, cap_data, cap_araddr, last_wr_addr;
   logic [2:0]  cap_prot;
   logic [3:0]  cap_strb;
   int          wr_count = 0, ar_count = 0, done_cnt = 0, wait_entry = -1, err_rise = -1;

   // AXI4-Lite slave: readies and responses change only on the falling edge.
   initial begin
      wr_t e;
      forever begin
         @(negedge clk);
         ncyc++;
         if (rst) begin
            m_axi_awready = 1'b0; m_axi_wready = 1'b0; m_axi_arready = 1'b0;
            m_axi_bvalid = 1'b0; m_axi_bresp = 2'b00;
            m_axi_rvalid = 1'b0; m_axi_rresp = 2'b00; m_axi_rdata = '0;
            interrupt_updone = 1'b0; irq_armed = 1'b0;
            hs_aw = 0; hs_w = 0; hs_b = 0; hs_ar = 0; hs_r = 0;
            got_aw = 0; got_w = 0; aw_run = 0; w_run = 0;
         end else begin
            if (hs_b) begin m_axi_bvalid = 1'b0; m_axi_bresp = 2'b00; end
            if (hs_r) begin m_axi_rvalid = 1'b0; m_axi_rresp = 2'b00; end
            if (hs_aw) got_aw = 1'b1;
            if (hs_w)  got_w  = 1'b1;
            if (got_aw && got_w) begin
               got_aw = 1'b0; got_w = 1'b0;
               wr_count++;
               n_cmp++;
               if (exp_q.size() == 0) begin
                  n_fail++;
                  $display("FAIL sb_write: unexpected write addr=%h data=%h, required no write", cap_addr, cap_data);
               end else begin
                  e = exp_q.pop_front();
                  if ({cap_addr, cap_data, cap_strb, cap_prot} !== {e.addr, e.data, 4'hF, 3'b000}) begin
                     n_fail++;
                     $display("FAIL sb_write: got addr=%h data=%h strb=%h prot=%h, required addr=%h data=%h strb=f prot=0",
                              cap_addr, cap_data, cap_strb, cap_prot, e.addr, e.data);
                  end else begin
                     $display("write addr=%h data=%h", cap_addr, cap_data);
                  end
               end
               m_axi_bvalid   = 1'b1;
               m_axi_bresp    = bresp_err_next ? 2'b10 : 2'b00;
               bresp_err_next = 1'b0;
               last_wr_addr   = cap_addr;
               if (cap_addr == UPENDR) begin interrupt_updone = 1'b0; irq_armed = 1'b0; end
            end
            if (hs_ar) begin
               m_axi_rvalid = 1'b1; m_axi_rdata = rd_value; m_axi_rresp = 2'b00;
               ar_count++;
               $display("read addr=%h data=%h", cap_araddr, rd_value);
            end
            if (irq_armed) begin
               if (irq_cnt == 0) interrupt_updone = 1'b1;
               else irq_cnt--;
            end
            if (m_axi_awvalid) begin
               if (aw_run == 0) aw_addr_hold = m_axi_awaddr;
               else if (m_axi_awaddr !== aw_addr_hold) aw_unstable++;
               aw_run++;
               m_axi_awready = (aw_run > aw_delay);
            end else begin
               aw_run = 0; m_axi_awready = 1'b0;
            end
            if (m_axi_wvalid) begin
               w_run++;
               m_axi_wready = (w_run > w_delay);
            end else begin
               w_run = 0; m_axi_wready = 1'b0;
            end
            m_axi_arready = m_axi_arvalid;
            hs_aw = m_axi_awvalid && m_axi_awready;
            hs_w  = m_axi_wvalid && m_axi_wready;
            hs_ar = m_axi_arvalid && m_axi_arready;
            hs_b  = m_axi_bvalid && m_axi_bready;
            hs_r  = m_axi_rvalid && m_axi_rready;
            if (hs_aw) begin
               cap_addr = m_axi_awaddr; cap_prot = m_axi_awprot;
               if (aw_len_first < 0) aw_len_first = aw_run;
            end
            if (hs_w) begin
               cap_data = m_axi_wdata; cap_strb = m_axi_wstrb;
               if (w_len_first < 0) w_len_first = w_run;
            end
            if (hs_ar) cap_araddr = m_axi_araddr;
            if (hs_b && last_wr_addr == UPSTR && m_axi_bresp == 2'b00) begin
               wait_entry   = ncyc + 1;
               wait_entered = 1'b1;
               if (irq_delay >= 0) begin irq_armed = 1'b1; irq_cnt = irq_delay; end
            end
         end
         if (done) done_cnt++;
         if (err && !err_prev) err_rise = ncyc;
         err_prev = err;
      end
   end

   task automatic start_batch(input logic [15:0] n);
      @(negedge clk); #1;
      interrupt_updone = 1'b0; irq_armed = 1'b0; wait_entered = 1'b0;
      aw_len_first = -1; w_len_first = -1; aw_unstable = 0; err_rise = -1;
      frame_num = n; start = 1'b1;
      @(negedge clk); #1;
      start = 1'b0;
   endtask

   task automatic wait_batch(input int snap, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 2000; i++) begin
         @(negedge clk); #1;
         if (done_cnt > snap) begin ok = 1'b1; break; end
      end
      repeat (3) @(negedge clk);
      #1;
   endtask

   task automatic push_frame_writes(input int frames, input bit with_clear);
      for (int i = 0; i < frames; i++) begin
         exp_q.push_back('{addr: UPSTR, data: 32'h1});
         if (with_clear) exp_q.push_back('{addr: UPENDR, data: 32'h0});
      end
   endtask

   task automatic test_reset;
      #1;
      n_cmp++;
      if ({busy, done, err, err_code, frames_done} !== 21'd0) begin
         n_fail++;
         $display("FAIL reset_status: got busy=%b done=%b err=%b code=%0d frames=%0d, required all 0",
                  busy, done, err, err_code, frames_done);
      end
      n_cmp++;
      if ({m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, m_axi_bready, m_axi_rready, m_axi_awaddr, m_axi_wdata, m_axi_araddr} !== '0) begin
         n_fail++;
         $display("FAIL reset_axi: got aw=%b w=%b ar=%b b=%b r=%b awaddr=%h wdata=%h araddr=%h, required all 0",
                  m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, m_axi_bready, m_axi_rready, m_axi_awaddr, m_axi_wdata, m_axi_araddr);
      end
      repeat (3) @(negedge clk);
      #1 rst = 1'b0;
      @(negedge clk); #1;
      n_cmp++;
      if ({busy, done} !== 2'b00) begin
         n_fail++;
         $display("FAIL reset_release: got busy=%b done=%b, required 0 0", busy, done);
      end
      $display("reset released");
   endtask

   task automatic test_two_frames;
      int snap_done, snap_ar;
      bit ok;
      irq_delay = 10; rd_value = 32'h1;
      push_frame_writes(2, 1'b1);
      snap_done = done_cnt; snap_ar = ar_count;
      start_batch(16'd2);
      wait_batch(snap_done, ok);
      n_cmp++;
      if (ok !== 1'b1) begin n_fail++; $display("FAIL two_frames_done: got no done pulse, required one"); end
      n_cmp++;
      if ({err, frames_done} !== {1'b0, 16'd2}) begin
         n_fail++;
         $display("FAIL two_frames_result: got err=%b frames=%0d, required err=0 frames=2", err, frames_done);
      end
      n_cmp++;
      if (done_cnt - snap_done !== 1) begin
         n_fail++;
         $display("FAIL two_frames_pulses: got %0d done pulses, required 1", done_cnt - snap_done);
      end
      n_cmp++;
      if (ar_count - snap_ar !== 2) begin
         n_fail++;
         $display("FAIL two_frames_reads: got %0d reads, required 2", ar_count - snap_ar);
      end
      n_cmp++;
      if (exp_q.size() !== 0) begin
         n_fail++;
         $display("FAIL two_frames_sb: got %0d writes missing, required 0", exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic test_zero_frames;
      int snap_done, snap_wr;
      snap_done = done_cnt; snap_wr = wr_count;
      start_batch(16'd0);
      n_cmp++;
      if ({done, busy} !== 2'b10) begin
         n_fail++;
         $display("FAIL zero_frames_pulse: got done=%b busy=%b, required done=1 busy=0", done, busy);
      end
      repeat (4) @(negedge clk);
      #1;
      n_cmp++;
      if ({done_cnt - snap_done, wr_count - snap_wr} !== {32'd1, 32'd0}) begin
         n_fail++;
         $display("FAIL zero_frames_count: got %0d pulses %0d writes, required 1 pulse 0 writes",
                  done_cnt - snap_done, wr_count - snap_wr);
      end
   endtask

   task automatic test_ignore_busy;
      int snap_done, snap_wr;
      bit ok;
      irq_delay = 4;
      push_frame_writes(1, 1'b1);
      snap_done = done_cnt; snap_wr = wr_count;
      start_batch(16'd1);
      repeat (3) @(negedge clk);
      #1 frame_num = 16'd7; start = 1'b1;
      @(negedge clk); #1 start = 1'b0;
      wait_batch(snap_done, ok);
      n_cmp++;
      if ({ok, frames_done, wr_count - snap_wr, done_cnt - snap_done} !== {1'b1, 16'd1, 32'd2, 32'd1}) begin
         n_fail++;
         $display("FAIL ignore_busy: got ok=%b frames=%0d writes=%0d pulses=%0d, required ok=1 frames=1 writes=2 pulses=1",
                  ok, frames_done, wr_count - snap_wr, done_cnt - snap_done);
      end
   endtask

   task automatic test_aw_delay;
      int snap_done;
      bit ok;
      irq_delay = 2; aw_delay = 3; w_delay = 0;
      push_frame_writes(1, 1'b1);
      snap_done = done_cnt;
      start_batch(16'd1);
      wait_batch(snap_done, ok);
      aw_delay = 0;
      n_cmp++;
      if ({aw_len_first, w_len_first} !== {32'd4, 32'd1}) begin
         n_fail++;
         $display("FAIL aw_delay_len: got awvalid %0d cycles wvalid %0d cycles, required 4 and 1", aw_len_first, w_len_first);
      end
      n_cmp++;
      if (aw_unstable !== 0) begin
         n_fail++;
         $display("FAIL aw_delay_stable: got %0d awaddr changes while valid, required 0", aw_unstable);
      end
      n_cmp++;
      if ({ok, err, frames_done} !== {1'b1, 1'b0, 16'd1}) begin
         n_fail++;
         $display("FAIL aw_delay_result: got ok=%b err=%b frames=%0d, required 1 0 1", ok, err, frames_done);
      end
   endtask

   task automatic test_bresp_err;
      int snap_done, snap_ar;
      bit ok;
      bresp_err_next = 1'b1;
      push_frame_writes(1, 1'b0);
      snap_done = done_cnt; snap_ar = ar_count;
      start_batch(16'd3);
      wait_batch(snap_done, ok);
      n_cmp++;
      if ({ok, err, err_code, frames_done} !== {1'b1, 1'b1, 2'd1, 16'd0}) begin
         n_fail++;
         $display("FAIL bresp_err: got ok=%b err=%b code=%0d frames=%0d, required 1 1 1 0", ok, err, err_code, frames_done);
      end
      n_cmp++;
      if ({ar_count - snap_ar, done_cnt - snap_done} !== {32'd0, 32'd1}) begin
         n_fail++;
         $display("FAIL bresp_err_side: got %0d reads %0d pulses, required 0 reads 1 pulse",
                  ar_count - snap_ar, done_cnt - snap_done);
      end
   endtask

   task automatic test_readback;
      int snap_done, snap_wr;
      bit ok;
      irq_delay = 3; rd_value = 32'h0;
      push_frame_writes(1, 1'b0);
      snap_done = done_cnt; snap_wr = wr_count;
      start_batch(16'd2);
      wait_batch(snap_done, ok);
      rd_value = 32'h1;
      n_cmp++;
      if ({ok, err, err_code, frames_done, wr_count - snap_wr} !== {1'b1, 1'b1, 2'd2, 16'd0, 32'd1}) begin
         n_fail++;
         $display("FAIL readback: got ok=%b err=%b code=%0d frames=%0d writes=%0d, required 1 1 2 0 1",
                  ok, err, err_code, frames_done, wr_count - snap_wr);
      end
   endtask

   task automatic test_timeout;
      int snap_done, snap_ar;
      bit ok;
      irq_delay = -1;
      push_frame_writes(1, 1'b0);
      snap_done = done_cnt; snap_ar = ar_count;
      start_batch(16'd1);
      wait_batch(snap_done, ok);
      n_cmp++;
      if ({ok, err, err_code, ar_count - snap_ar} !== {1'b1, 1'b1, 2'd3, 32'd0}) begin
         n_fail++;
         $display("FAIL timeout_code: got ok=%b err=%b code=%0d reads=%0d, required 1 1 3 0",
                  ok, err, err_code, ar_count - snap_ar);
      end
      n_cmp++;
      if (err_rise - wait_entry !== 16) begin
         n_fail++;
         $display("FAIL timeout_latency: got %0d cycles from wait entry to error, required 16", err_rise - wait_entry);
      end
   endtask

   task automatic test_reset_mid;
      int snap_done;
      bit ok;
      bit entered;
      irq_delay = -1;
      push_frame_writes(1, 1'b0);
      start_batch(16'd5);
      entered = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk); #1;
         if (wait_entered) begin entered = 1'b1; break; end
      end
      n_cmp++;
      if (entered !== 1'b1) begin n_fail++; $display("FAIL reset_mid_wait: got no wait entry, required one"); end
      repeat (3) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      n_cmp++;
      if ({busy, done, err, err_code, frames_done, m_axi_awvalid, m_axi_wvalid, m_axi_arvalid,
           m_axi_bready, m_axi_rready, m_axi_awaddr, m_axi_wdata, m_axi_araddr} !== '0) begin
         n_fail++;
         $display("FAIL reset_mid_outputs: got busy=%b done=%b err=%b frames=%0d aw=%b w=%b ar=%b, required all 0",
                  busy, done, err, frames_done, m_axi_awvalid, m_axi_wvalid, m_axi_arvalid);
      end
      repeat (3) @(negedge clk);
      #1 rst = 1'b0;
      n_cmp++;
      if (exp_q.size() !== 0) begin
         n_fail++;
         $display("FAIL reset_mid_sb: got %0d writes missing, required 0", exp_q.size());
         exp_q.delete();
      end
      irq_delay = 5;
      push_frame_writes(1, 1'b1);
      snap_done = done_cnt;
      start_batch(16'd1);
      wait_batch(snap_done, ok);
      n_cmp++;
      if ({ok, err, frames_done, exp_q.size()} !== {1'b1, 1'b0, 16'd1, 32'd0}) begin
         n_fail++;
         $display("FAIL reset_mid_restart: got ok=%b err=%b frames=%0d pending=%0d, required 1 0 1 0",
                  ok, err, frames_done, exp_q.size());
      end
   endtask

   initial begin
      test_reset;
      test_two_frames;
      test_zero_frames;
      test_ignore_busy;
      test_aw_delay;
      test_bresp_err;
      test_readback;
      test_timeout;
      test_reset_mid;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule

// File: doc/upsp_frame_sequencer.md
UPSP_FRAME_SEQUENCER -- requirements
Module: upsp_frame_sequencer

Interface
REQ-001 Parameters: AXI_ADDR_WIDTH, default 32, lite address width.
REQ-002 AXI_DATA_WIDTH, default 32, lite data width.
REQ-003 UPSTR_ADDR, default 'h0, UPSTART register address.
REQ-004 UPENDR_ADDR, default 'h4, UPEND register address.
REQ-005 TIMEOUT_CYCLES, default 2**20, maximum wait for frame completion.
REQ-006 Reset is asynchronous and active-high, and the block has one clock; ports are clk (in, 1, clock) and rst (in, 1, async active-high reset).
REQ-007 start, in, 1: single-cycle request to run a frame batch. frame_num, in, 16: number of frames.
REQ-008 busy, out, 1, batch active. done, out, 1, one-cycle batch-complete pulse.
REQ-009 err, out, 1, sticky error. err_code, out, 2: 1 = BRESP, 2 = RRESP/readback mismatch, 3 = timeout. frames_done, out, 16, completed-frame count.
REQ-010 interrupt_updone, in, 1: level from config register file.
REQ-011 AXI4-Lite master ports, all 1 bit unless noted:
- m_axi_awvalid out; m_axi_awready in; m_axi_awaddr out, AXI_ADDR_WIDTH; m_axi_awprot out, 3.
- m_axi_wvalid out; m_axi_wready in; m_axi_wdata out, AXI_DATA_WIDTH; m_axi_wstrb out, AXI_DATA_WIDTH/8.
- m_axi_bvalid in; m_axi_bready out; m_axi_bresp in, 2.
- m_axi_arvalid out; m_axi_arready in; m_axi_araddr out, AXI_ADDR_WIDTH; m_axi_arprot out, 3.
- m_axi_rvalid in; m_axi_rready out; m_axi_rdata in, AXI_DATA_WIDTH; m_axi_rresp in, 2.

Function
REQ-012 States: IDLE, WR_START, WR_START_B, WAIT_DONE, RD_END, RD_END_R, WR_CLR, WR_CLR_B, NEXT, FAIL.
REQ-013 IDLE: start=1 with frame_num!=0 -> WR_START, latch frame_num, clear frames_done and err. start with frame_num==0 -> done pulse next cycle, stay IDLE. start while busy is ignored.
REQ-014 WR_START: assert awvalid and wvalid together (awaddr=UPSTR_ADDR, wdata=1, wstrb all ones, awprot=0). Each valid drops independently on its own handshake; both done -> WR_START_B.
REQ-015 WR_CLR: identical to WR_START with awaddr=UPENDR_ADDR, wdata=0; -> WR_CLR_B.
REQ-016 *_B states: bready=1. On bvalid: bresp!=0 -> FAIL with code 1; else WR_START_B -> WAIT_DONE, WR_CLR_B -> NEXT.
REQ-017 WAIT_DONE: 32-bit cycle counter clears on entry. interrupt_updone=1 -> RD_END. Counter reaching TIMEOUT_CYCLES-1 without interrupt -> FAIL with code 3. An interrupt in the same cycle as the timeout wins.
REQ-018 RD_END: arvalid=1, araddr=UPENDR_ADDR, arprot=0; on arready -> RD_END_R.
REQ-019 RD_END_R: rready=1. On rvalid: rresp!=0 or rdata[0]!=1 -> FAIL with code 2; else -> WR_CLR.
REQ-020 NEXT: frames_done += 1. If the incremented value equals the latched count -> IDLE with done pulse; else -> WR_START. Lasts one cycle.
REQ-021 FAIL: err=1 and err_code hold until the next accepted start. Returns to IDLE the next cycle with a done pulse. busy=0 in IDLE only.
REQ-022 Valid signals never deassert before their handshake, and payload stays stable while valid is high. No new transaction issues while a response is outstanding.
REQ-023 frames_done saturates at 16'hFFFF and does not wrap.

Reset
REQ-024 rst asynchronously forces IDLE and drives all valid/ready outputs, busy, done, err, err_code and frames_done to 0; address/data outputs to 0.
REQ-025 rst mid-transaction abandons it without completing the handshake; the first start after deassertion begins a fresh batch.

Verification
REQ-026 frame_num=2, zero-wait slave, interrupt after 10 cycles -> write sequence UPSTR=1, UPENDR=0, UPSTR=1, UPENDR=0; frames_done=2; one done pulse; err=0.
REQ-027 awready delayed 3 cycles, wready immediate -> wvalid drops after 1 cycle, awvalid held 4 cycles with stable awaddr.
REQ-028 bresp=2'b10 on first write -> err=1, err_code=1, frames_done=0, done pulse, no AR issued.
REQ-029 TIMEOUT_CYCLES=16, interrupt never asserted -> FAIL exactly 16 cycles after WAIT_DONE entry, err_code=3.
REQ-030 rdata=0 on readback -> err_code=2, no clear write.
REQ-031 rst asserted during WAIT_DONE with frame_num=5 -> all outputs 0 immediately; a new start with frame_num=1 completes with frames_done=1.
